// File: rtl/rule_cfg_pkg.sv
// Shared types and constants for the rule-configuration write sequencer:
// FSM states, address-select encodings, descriptor layout and address builder.
package rule_cfg_pkg;

  localparam int RC_TYPE_NUM         = 4;
  localparam int RC_KEY_FIELD_NUM    = 8;
  localparam int RC_TYPE_WIDTH       = 16;
  localparam int RC_KEY_OFFSET_WIDTH = 6;

  localparam logic [1:0] SEL_RULE = 2'b00;
  localparam logic [1:0] SEL_TYPE = 2'b01;
  localparam logic [1:0] SEL_KEY  = 2'b10;

  // Set on every rule-side write; clear for type-offset writes.
  localparam int ADDR_RULE_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOFF   = 3'd1,
    ST_INVAL  = 3'd2,
    ST_TYPE   = 3'd3,
    ST_KEY    = 3'd4,
    ST_COMMIT = 3'd5,
    ST_DONE   = 3'd6
  } rc_state_e;

  typedef struct packed {
    logic [5:0]                                      id;
    logic                                            en;
    logic [RC_TYPE_NUM*RC_TYPE_WIDTH-1:0]            type_data;
    logic [RC_TYPE_NUM*RC_TYPE_WIDTH-1:0]            type_mask;
    logic [RC_KEY_FIELD_NUM*RC_KEY_OFFSET_WIDTH-1:0] key_offset;
  } rule_desc_t;

  function automatic logic [31:0] rule_side_addr(input logic [1:0] sel, input logic [5:0] low);
    logic [31:0] a;
    a                = 32'h0000_0000;
    a[ADDR_RULE_BIT] = 1'b1;
    a[9:8]           = sel;
    a[5:0]           = low;
    return a;
  endfunction

endpackage

// File: rtl/rule_cfg_arb.sv
// Two-requester round-robin arbiter (type-offset vs rule descriptor) with a
// last-served pointer; grants are combinational and gated by i_en.
module rule_cfg_arb (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_toff,
  input  logic i_req_rule,
  output logic o_gnt_toff,
  output logic o_gnt_rule
);

  logic last_rule_q;
  logic last_rule_d;

  // Grant selection and pointer update; on contention the port not served last wins.
  always_comb begin
    o_gnt_toff = 1'b0;
    o_gnt_rule = 1'b0;
    if (!i_en) begin
      o_gnt_toff = 1'b0;
    end else if (i_req_toff && i_req_rule) begin
      o_gnt_toff = last_rule_q;
      o_gnt_rule = !last_rule_q;
    end else begin
      o_gnt_toff = i_req_toff;
      o_gnt_rule = i_req_rule;
    end
    if (o_gnt_rule) begin
      last_rule_d = 1'b1;
    end else if (o_gnt_toff) begin
      last_rule_d = 1'b0;
    end else begin
      last_rule_d = last_rule_q;
    end
  end

  // Pointer resets as if the rule port was served last, so type-offset goes first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_rule_q <= 1'b1;
    end else begin
      last_rule_q <= last_rule_d;
    end
  end

endmodule

// File: rtl/rule_cfg_sequencer.sv
// Serialises rule descriptors and type-offset updates onto the single-word rule
// configuration bus. Optional macro RULE_CFG_INVALIDATE_EN prepends an invalidate write.
module rule_cfg_sequencer
  import rule_cfg_pkg::*;
#(
  parameter int TYPE_NUM          = RC_TYPE_NUM,
  parameter int KEY_FIELD_NUM     = RC_KEY_FIELD_NUM,
  parameter int RULE_NUM          = 16,
  parameter int TYPE_WIDTH        = RC_TYPE_WIDTH,
  parameter int KEY_OFFSET_WIDTH  = RC_KEY_OFFSET_WIDTH,
  parameter int TYPE_OFFSET_WIDTH = 6
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_rule_valid,
  output logic                                      o_rule_ready,
  input  logic [5:0]                                i_rule_id,
  input  logic                                      i_rule_en,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_type_data,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_type_mask,
  input  logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] i_key_offset,
  input  logic                                      i_toff_valid,
  output logic                                      o_toff_ready,
  input  logic [3:0]                                i_toff_id,
  input  logic [TYPE_OFFSET_WIDTH-1:0]              i_toff_value,
  output logic                                      o_rule_wren,
  output logic [31:0]                               o_rule_wdata,
  output logic [31:0]                               o_rule_addr,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic                                      o_err
);

  localparam int IDX_W = $clog2((TYPE_NUM > KEY_FIELD_NUM) ? TYPE_NUM : KEY_FIELD_NUM);

  rc_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  rule_desc_t       desc_q, desc_d;
  logic             wren_q, wren_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  rule_desc_t       desc_in_s;
  logic [IDX_W-1:0] idx_nx_s;
  logic             idle_s;
  logic             gnt_toff_s;
  logic             gnt_rule_s;

  function automatic logic [31:0] type_wdata(input rule_desc_t d, input logic [IDX_W-1:0] k);
    return {d.type_data[k*TYPE_WIDTH +: TYPE_WIDTH], d.type_mask[k*TYPE_WIDTH +: TYPE_WIDTH]};
  endfunction

  function automatic logic [31:0] key_wdata(input rule_desc_t d, input logic [IDX_W-1:0] k);
    return 32'(d.key_offset[k*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH]);
  endfunction

  assign desc_in_s    = {i_rule_id, i_rule_en, i_type_data, i_type_mask, i_key_offset};
  assign idx_nx_s     = idx_q + IDX_W'(1);
  assign idle_s       = (state_q == ST_IDLE);
  assign o_rule_ready = gnt_rule_s;
  assign o_toff_ready = gnt_toff_s;

  rule_cfg_arb u_arb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (idle_s),
    .i_req_toff (i_toff_valid),
    .i_req_rule (i_rule_valid),
    .o_gnt_toff (gnt_toff_s),
    .o_gnt_rule (gnt_rule_s)
  );

  // Next state plus the write that will sit on the bus in the following cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    desc_d  = desc_q;
    wren_d  = 1'b0;
    addr_d  = 32'h0000_0000;
    wdata_d = 32'h0000_0000;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_toff_s) begin
          state_d = ST_TOFF;
          idx_d   = '0;
          wren_d  = 1'b1;
          addr_d  = {28'h000_0000, i_toff_id};
          wdata_d = 32'(i_toff_value);
        end else if (gnt_rule_s) begin
          desc_d = desc_in_s;
          idx_d  = '0;
          if (int'(i_rule_id) >= RULE_NUM) begin
            err_d = 1'b1;
          end else begin
            wren_d = 1'b1;
`ifdef RULE_CFG_INVALIDATE_EN
            state_d = ST_INVAL;
            addr_d  = rule_side_addr(SEL_RULE, i_rule_id);
            wdata_d = 32'h0000_0000;
`else
            state_d = ST_TYPE;
            addr_d  = rule_side_addr(SEL_TYPE, 6'h00);
            wdata_d = type_wdata(desc_in_s, '0);
`endif
          end
        end else begin
          idx_d = '0;
        end
      end
`ifdef RULE_CFG_INVALIDATE_EN
      ST_INVAL: begin
        state_d = ST_TYPE;
        idx_d   = '0;
        wren_d  = 1'b1;
        addr_d  = rule_side_addr(SEL_TYPE, 6'h00);
        wdata_d = type_wdata(desc_q, '0);
      end
`endif
      ST_TYPE: begin
        wren_d = 1'b1;
        if (idx_q == IDX_W'(TYPE_NUM - 1)) begin
          state_d = ST_KEY;
          idx_d   = '0;
          addr_d  = rule_side_addr(SEL_KEY, 6'h00);
          wdata_d = key_wdata(desc_q, '0);
        end else begin
          idx_d   = idx_nx_s;
          addr_d  = rule_side_addr(SEL_TYPE, 6'(idx_nx_s));
          wdata_d = type_wdata(desc_q, idx_nx_s);
        end
      end
      ST_KEY: begin
        wren_d = 1'b1;
        if (idx_q == IDX_W'(KEY_FIELD_NUM - 1)) begin
          // Commit goes last so the rule only becomes live once every field is written.
          state_d = ST_COMMIT;
          idx_d   = '0;
          addr_d  = rule_side_addr(SEL_RULE, desc_q.id);
          wdata_d = {31'h0000_0000, desc_q.en};
        end else begin
          idx_d   = idx_nx_s;
          addr_d  = rule_side_addr(SEL_KEY, 6'(idx_nx_s));
          wdata_d = key_wdata(desc_q, idx_nx_s);
        end
      end
      ST_TOFF, ST_COMMIT: begin
        state_d = ST_DONE;
        idx_d   = '0;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = wren_d;
  end

  // Sequencer state and registered write-bus outputs; reset drops any captured descriptor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      desc_q  <= '0;
      wren_q  <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      desc_q  <= desc_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_rule_wren  = wren_q;
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_rule_cfg_sequencer.sv
// Self-checking bench for rule_cfg_sequencer: random requests checked against a
// write-list / timeline model derived from the address map and burst order.
module tb_rule_cfg_sequencer;

  localparam int TYPE_NUM      = 4;
  localparam int KEY_FIELD_NUM = 8;
`ifdef RULE_CFG_INVALIDATE_EN
  localparam int INVAL_W = 1;
`else
  localparam int INVAL_W = 0;
`endif
  localparam int RULE_LEN = TYPE_NUM + KEY_FIELD_NUM + 1 + INVAL_W;
  localparam int B2B_CYC  = 70;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rule_valid = 1'b0;
  logic        rule_ready;
  logic [5:0]  rule_id = 6'h00;
  logic        rule_en = 1'b0;
  logic [63:0] type_data = 64'h0;
  logic [63:0] type_mask = 64'h0;
  logic [47:0] key_off = 48'h0;
  logic        toff_valid = 1'b0;
  logic        toff_ready;
  logic [3:0]  toff_id = 4'h0;
  logic [5:0]  toff_value = 6'h00;
  logic        wren;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        rrdy;
    logic        trdy;
  } sample_t;

  sample_t     obs[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_wdata[$];

  rule_cfg_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rule_valid (rule_valid),
    .o_rule_ready (rule_ready),
    .i_rule_id    (rule_id),
    .i_rule_en    (rule_en),
    .i_type_data  (type_data),
    .i_type_mask  (type_mask),
    .i_key_offset (key_off),
    .i_toff_valid (toff_valid),
    .o_toff_ready (toff_ready),
    .i_toff_id    (toff_id),
    .i_toff_value (toff_value),
    .o_rule_wren  (wren),
    .o_rule_wdata (wdata),
    .o_rule_addr  (addr),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: the ordered word writes a legal rule descriptor expands into.
  function automatic void model_rule(input logic [5:0] id, input logic en, input logic [63:0] d,
                                     input logic [63:0] m, input logic [47:0] k);
    exp_addr.delete();
    exp_wdata.delete();
    if (INVAL_W == 1) begin
      exp_addr.push_back(32'h0001_0000 + 32'(id));
      exp_wdata.push_back(32'h0);
    end
    for (int t = 0; t < TYPE_NUM; t++) begin
      exp_addr.push_back(32'h0001_0100 + 32'(t));
      exp_wdata.push_back({d[t*16 +: 16], m[t*16 +: 16]});
    end
    for (int f = 0; f < KEY_FIELD_NUM; f++) begin
      exp_addr.push_back(32'h0001_0200 + 32'(f));
      exp_wdata.push_back(32'(k[f*6 +: 6]));
    end
    exp_addr.push_back(32'h0001_0000 + 32'(id));
    exp_wdata.push_back({31'h0, en});
  endfunction

  function automatic void model_toff(input logic [3:0] id, input logic [5:0] v);
    exp_addr.delete();
    exp_wdata.delete();
    exp_addr.push_back(32'(id));
    exp_wdata.push_back(32'(v));
  endfunction

  task automatic scramble();
    rule_id    = 6'($urandom);
    rule_en    = 1'($urandom);
    type_data  = {$urandom, $urandom};
    type_mask  = {$urandom, $urandom};
    key_off    = 48'({$urandom, $urandom});
    toff_id    = 4'($urandom);
    toff_value = 6'($urandom);
  endtask

  task automatic issue_rule(input logic [5:0] id, input logic en, input logic [63:0] d,
                            input logic [63:0] m, input logic [47:0] k, output bit ok);
    @(negedge clk);
    rule_id = id; rule_en = en; type_data = d; type_mask = m; key_off = k;
    rule_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      #1;
      if (rule_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    rule_valid = 1'b0;
    scramble();
  endtask

  task automatic issue_toff(input logic [3:0] id, input logic [5:0] v, output bit ok);
    @(negedge clk);
    toff_id = id; toff_value = v;
    toff_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      #1;
      if (toff_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    toff_valid = 1'b0;
    scramble();
  endtask

  // Records one sample per cycle at the falling edge; sample 0 is cycle 1 after accept.
  task automatic collect(input int n);
    sample_t s;
    obs.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      s.wren = wren; s.addr = addr; s.wdata = wdata; s.busy = busy;
      s.done = done; s.err = err; s.rrdy = rule_ready; s.trdy = toff_ready;
      obs.push_back(s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wren, addr, wdata, busy, done, err, rule_ready, toff_ready} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_in: got wren=%b addr=%h wdata=%h busy=%b done=%b err=%b rr=%b tr=%b, expected all 0",
               wren, addr, wdata, busy, done, err, rule_ready, toff_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wren, addr, wdata, busy, done, err, rule_ready, toff_ready} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_out: got wren=%b addr=%h busy=%b done=%b err=%b, expected all 0",
               wren, addr, busy, done, err);
    end
  endtask

  task automatic test_rule();
    logic [63:0] d, m;
    logic [47:0] k;
    logic [5:0]  id;
    logic        en;
    logic [3:0]  ef;
    bit          ok;
    int          len, nw;
    for (int it = 0; it < 12; it++) begin
      d  = {$urandom, $urandom};
      m  = {$urandom, $urandom};
      k  = 48'({$urandom, $urandom});
      en = 1'($urandom);
      id = 6'($urandom_range(0, 15));
      if (it == 0) begin
        id = 6'd3; en = 1'b1;
        d  = {16'h0000, 16'h8100, 16'h86DD, 16'h0800};
        m  = {16'h0000, 16'h0FFF, 16'hFFFF, 16'hFFFF};
        for (int f = 0; f < KEY_FIELD_NUM; f++) k[f*6 +: 6] = 6'(2 * (f + 1));
      end else if (it == 1) begin
        id = 6'd7; en = 1'b1;
      end
      model_rule(id, en, d, m, k);
      len = exp_addr.size();
      issue_rule(id, en, d, m, k, ok);
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL rule_accept it=%0d: ready never seen", it);
      end
      collect(len + 3);
      nw = 0;
      for (int c = 1; c <= len + 2; c++) begin
        ef = {c <= len, c <= len, c == len + 1, 1'b0};
        nw += int'(obs[c-1].wren);
        n_checks++;
        if ({obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err} !== ef) begin
          n_fail++;
          $display("FAIL rule_flags it=%0d cyc=%0d: wren/busy/done/err got %b expected %b", it, c,
                   {obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err}, ef);
        end
        if (c <= len) begin
          n_checks++;
          if ({obs[c-1].addr, obs[c-1].wdata} !== {exp_addr[c-1], exp_wdata[c-1]}) begin
            n_fail++;
            $display("FAIL rule_write it=%0d cyc=%0d: got %h/%h expected %h/%h", it, c,
                     obs[c-1].addr, obs[c-1].wdata, exp_addr[c-1], exp_wdata[c-1]);
          end
        end
      end
      n_checks++;
      if (nw !== 13 + INVAL_W) begin
        n_fail++;
        $display("FAIL rule_len it=%0d: got %0d writes expected %0d", it, nw, 13 + INVAL_W);
      end
      if (it == 0) begin
        n_checks++;
        if ({obs[len-1].addr, obs[len-1].wdata, obs[len].done} !== {32'h0001_0003, 32'h1, 1'b1}) begin
          n_fail++;
          $display("FAIL rule3_commit: got %h/%h done=%b expected 00010003/00000001 done=1",
                   obs[len-1].addr, obs[len-1].wdata, obs[len].done);
        end
      end
`ifdef RULE_CFG_INVALIDATE_EN
      if (it == 1) begin
        n_checks++;
        if ({obs[0].addr, obs[0].wdata} !== {32'h0001_0007, 32'h0}) begin
          n_fail++;
          $display("FAIL inval_first: got %h/%h expected 00010007/00000000", obs[0].addr, obs[0].wdata);
        end
      end
`endif
    end
  endtask

  task automatic test_toff();
    logic [3:0] id;
    logic [5:0] v;
    logic [3:0] ef;
    bit         ok;
    for (int it = 0; it < 10; it++) begin
      id = 4'($urandom);
      v  = 6'($urandom);
      if (it == 0) begin
        id = 4'd2; v = 6'd14;
      end
      model_toff(id, v);
      issue_toff(id, v, ok);
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL toff_accept it=%0d: ready never seen", it);
      end
      collect(4);
      for (int c = 1; c <= 3; c++) begin
        ef = {c == 1, c == 1, c == 2, 1'b0};
        n_checks++;
        if ({obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err} !== ef) begin
          n_fail++;
          $display("FAIL toff_flags it=%0d cyc=%0d: got %b expected %b", it, c,
                   {obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err}, ef);
        end
      end
      n_checks++;
      if ({obs[0].addr, obs[0].wdata} !== {exp_addr[0], exp_wdata[0]}) begin
        n_fail++;
        $display("FAIL toff_write it=%0d: got %h/%h expected %h/%h", it, obs[0].addr, obs[0].wdata,
                 exp_addr[0], exp_wdata[0]);
      end
      if (it == 0) begin
        n_checks++;
        if ({obs[0].addr, obs[0].wdata} !== {32'h2, 32'hE}) begin
          n_fail++;
          $display("FAIL toff2_write: got %h/%h expected 00000002/0000000e", obs[0].addr, obs[0].wdata);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] id;
    logic [3:0] ef;
    bit         ok;
    for (int it = 0; it < 5; it++) begin
      id = (it == 0) ? 6'd20 : 6'($urandom_range(16, 63));
      issue_rule(id, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 48'($urandom), ok);
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_accept id=%0d: ready never seen", id);
      end
      collect(5);
      for (int c = 1; c <= 5; c++) begin
        ef = {1'b0, 1'b0, 1'b0, c == 1};
        n_checks++;
        if ({obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err} !== ef) begin
          n_fail++;
          $display("FAIL illegal_flags id=%0d cyc=%0d: got %b expected %b", id, c,
                   {obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err}, ef);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[$], td[$], ra[$], rd[$];
    logic [1:0]  exp_g[B2B_CYC];
    logic        exp_w[B2B_CYC];
    logic        exp_dn[B2B_CYC];
    logic [31:0] exp_a[B2B_CYC];
    logic [31:0] exp_d[B2B_CYC];
    int          t, len;
    bit          is_rule;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    toff_id = 4'($urandom); toff_value = 6'($urandom);
    rule_id = 6'($urandom_range(0, 15)); rule_en = 1'($urandom);
    type_data = {$urandom, $urandom}; type_mask = {$urandom, $urandom};
    key_off = 48'({$urandom, $urandom});
    model_toff(toff_id, toff_value);
    ta = exp_addr; td = exp_wdata;
    model_rule(rule_id, rule_en, type_data, type_mask, key_off);
    ra = exp_addr; rd = exp_wdata;
    for (int i = 0; i < B2B_CYC; i++) begin
      exp_g[i] = 2'b00; exp_w[i] = 1'b0; exp_dn[i] = 1'b0; exp_a[i] = 32'h0; exp_d[i] = 32'h0;
    end
    // Timeline: grant, burst of len writes, done, then next grant; ports alternate from toff.
    t = 0;
    is_rule = 1'b0;
    while (t < B2B_CYC) begin
      len = is_rule ? ra.size() : ta.size();
      exp_g[t] = is_rule ? 2'b10 : 2'b01;
      for (int j = 0; j < len; j++) begin
        if (t + 1 + j < B2B_CYC) begin
          exp_w[t+1+j] = 1'b1;
          exp_a[t+1+j] = is_rule ? ra[j] : ta[j];
          exp_d[t+1+j] = is_rule ? rd[j] : td[j];
        end
      end
      if (t + len + 1 < B2B_CYC) exp_dn[t+len+1] = 1'b1;
      t += len + 2;
      is_rule = !is_rule;
    end
    @(posedge clk);
    #1;
    rule_valid = 1'b1;
    toff_valid = 1'b1;
    collect(B2B_CYC);
    for (int i = 0; i < B2B_CYC; i++) begin
      n_checks++;
      if ({obs[i].rrdy, obs[i].trdy, obs[i].wren, obs[i].done} !== {exp_g[i], exp_w[i], exp_dn[i]}) begin
        n_fail++;
        $display("FAIL b2b_flags cyc=%0d: rr/tr/wren/done got %b expected %b", i,
                 {obs[i].rrdy, obs[i].trdy, obs[i].wren, obs[i].done}, {exp_g[i], exp_w[i], exp_dn[i]});
      end
      if (exp_w[i]) begin
        n_checks++;
        if ({obs[i].addr, obs[i].wdata} !== {exp_a[i], exp_d[i]}) begin
          n_fail++;
          $display("FAIL b2b_write cyc=%0d: got %h/%h expected %h/%h", i, obs[i].addr, obs[i].wdata,
                   exp_a[i], exp_d[i]);
        end
      end
    end
    rule_valid = 1'b0;
    toff_valid = 1'b0;
    repeat (RULE_LEN + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] ef;
    logic [3:0] id;
    logic [5:0] v;
    bit         ok;
    model_rule(6'($urandom_range(0, 15)), 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 48'($urandom));
    issue_rule(6'(exp_addr[exp_addr.size()-1]), 1'b1, 64'h0, 64'h0, 48'h0, ok);
    collect(5);
    n_checks++;
    if ({ok, obs[4].wren, obs[4].busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL midburst_pre: accept/wren/busy at write 5 got %b expected 111", {ok, obs[4].wren, obs[4].busy});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wren, addr, wdata, busy, done, err, rule_ready, toff_ready} !== 70'h0) begin
      n_fail++;
      $display("FAIL midburst_rst: got wren=%b addr=%h wdata=%h busy=%b done=%b err=%b, expected all 0",
               wren, addr, wdata, busy, done, err);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({wren, addr, wdata, busy, done, err} !== 68'h0) begin
      n_fail++;
      $display("FAIL midburst_hold: got wren=%b addr=%h busy=%b done=%b, expected all 0", wren, addr, busy, done);
    end
    rst_n = 1'b1;
    id = 4'($urandom);
    v  = 6'($urandom);
    model_toff(id, v);
    issue_toff(id, v, ok);
    collect(4);
    for (int c = 1; c <= 4; c++) begin
      ef = {c == 1, c == 1, c == 2, 1'b0};
      n_checks++;
      if ({obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err} !== ef) begin
        n_fail++;
        $display("FAIL post_rst_flags cyc=%0d: got %b expected %b", c,
                 {obs[c-1].wren, obs[c-1].busy, obs[c-1].done, obs[c-1].err}, ef);
      end
    end
    n_checks++;
    if ({ok, obs[0].addr, obs[0].wdata} !== {1'b1, exp_addr[0], exp_wdata[0]}) begin
      n_fail++;
      $display("FAIL post_rst_write: ok=%b got %h/%h expected %h/%h", ok, obs[0].addr, obs[0].wdata,
               exp_addr[0], exp_wdata[0]);
    end
  endtask

  initial begin
    test_reset();
    test_rule();
    test_toff();
    test_illegal();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
